// File: rtl/mic1_clk_ctrl.sv
// mic1_clk_ctrl: execution-clock controller for the MIC-1 datapath.
// Turns run/step/speed requests into a registered single-cycle clock enable,
// counts issued microcycles and parks in HALTED when the datapath halts.
module mic1_clk_ctrl #(
   parameter int DIV_W = 16,
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_run_en,
   input  logic             i_step_req,
   input  logic [3:0]       i_speed_sel,
   input  logic             i_cpu_halt,
   output logic             o_cpu_ce,
   output logic             o_running,
   output logic             o_halted,
   output logic [CNT_W-1:0] o_cycle_count
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STEP   = 2'd1,
      ST_RUN    = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_state_nxt;
   logic [DIV_W-1:0] r_div_cnt;
   logic [DIV_W-1:0] w_div_nxt;
   logic [DIV_W-1:0] w_term;
   logic             w_ce_nxt;
   logic             r_cpu_ce;
   logic             r_running;
   logic             r_halted;
   logic [CNT_W-1:0] r_cycle_count;

   // Terminal count follows speed_sel live, so a speed change acts immediately.
   always_comb begin
      w_term = (DIV_ONE << i_speed_sel) - DIV_ONE;
   end

   // Next-state, prescaler and clock-enable decision for the coming edge.
   always_comb begin
      w_state_nxt = r_state;
      w_div_nxt   = r_div_cnt;
      w_ce_nxt    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_cpu_halt) begin
               w_state_nxt = ST_IDLE;
            end else if (i_run_en) begin
               w_state_nxt = ST_RUN;
               w_div_nxt   = '0;
            end else if (i_step_req) begin
               w_state_nxt = ST_STEP;
               w_ce_nxt    = 1'b1;
            end
         end
         ST_STEP: begin
            // The enable for this step was registered on entry; just return.
            w_state_nxt = ST_IDLE;
         end
         ST_RUN: begin
            if (i_cpu_halt) begin
               w_state_nxt = ST_HALTED;
            end else if (!i_run_en) begin
               w_state_nxt = ST_IDLE;
               w_div_nxt   = '0;
            end else if (r_div_cnt >= w_term) begin
               w_ce_nxt  = 1'b1;
               w_div_nxt = '0;
            end else begin
               w_div_nxt = r_div_cnt + DIV_ONE;
            end
         end
         ST_HALTED: begin
            if (!i_run_en) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_div_nxt   = '0;
         end
      endcase
   end

   // State, prescaler, registered outputs and microcycle counter.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= ST_IDLE;
         r_div_cnt     <= '0;
         r_cpu_ce      <= 1'b0;
         r_running     <= 1'b0;
         r_halted      <= 1'b0;
         r_cycle_count <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_div_cnt <= w_div_nxt;
         r_cpu_ce  <= w_ce_nxt;
         r_running <= (w_state_nxt == ST_RUN);
         r_halted  <= (w_state_nxt == ST_HALTED);
         if (w_ce_nxt) begin
            r_cycle_count <= r_cycle_count + CNT_ONE;
         end
      end
   end

   assign o_cpu_ce      = r_cpu_ce;
   assign o_running     = r_running;
   assign o_halted      = r_halted;
   assign o_cycle_count = r_cycle_count;

endmodule

// File: doc/mic1_clk_ctrl.md
# mic1_clk_ctrl

Execution-clock controller directly downstream of `button_fsm`. It consumes the debounced start/stop level, the single-step pulse and the 4-bit run-speed selection, and produces a single-cycle clock-enable `cpu_ce` that advances the MIC-1 microarchitecture by one microinstruction. It also counts issued microcycles and stops execution when the datapath raises a halt.

## Interface
- `DIV_W`, 16: prescaler counter width; must be ≥ 15.
- `CNT_W`, 16: microcycle counter width.

- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `run_en`  in  1  level, 1 = free-run requested (from `led_start_stop`).
- `step_req`  in  1  single-cycle pulse, 1 = execute one microinstruction (from `led_step`).
- `speed_sel`  in  4  run speed s; in RUN one `cpu_ce` every 2^s clocks (from `led_run`).
- `cpu_halt`  in  1  level from datapath, 1 = halt condition reached.
- `cpu_ce`  out  1  registered clock-enable pulse to the datapath.
- `running`  out  1  1 while state = RUN.
- `halted`  out  1  1 while state = HALTED.
- `cycle_count`  out  CNT_W  number of `cpu_ce` pulses issued, wrapping.

## Operation
- Synchronous active-high reset: one clock, one clock domain; on reset state = IDLE, `div_cnt` = 0, `cpu_ce` = 0, `running` = 0, `halted` = 0, `cycle_count` = 0. Reset has priority over every other input, including mid-RUN or mid-STEP.
- Terminal value term = 2^s − 1, where s = `speed_sel` sampled each cycle (not latched).
- States and transitions (evaluated each rising edge, priority top to bottom):
  - IDLE: `cpu_halt`=1 → stay IDLE. `run_en`=1 → RUN, `div_cnt` ← 0. `step_req`=1 → STEP. Otherwise stay. Run beats step when both are asserted.
  - STEP: `cpu_ce` high for this state's single cycle; unconditionally → IDLE. `step_req` during STEP is dropped.
  - RUN: `cpu_halt`=1 → HALTED, no pulse. `run_en`=0 → IDLE, `div_cnt` ← 0, no pulse. `div_cnt` ≥ term → `cpu_ce` pulse, `div_cnt` ← 0. Otherwise `div_cnt` ← `div_cnt`+1. `step_req` is ignored.
  - HALTED: `cpu_ce` = 0. `run_en`=0 → IDLE; otherwise stay. `step_req` is ignored.
- Comparison uses ≥, so lowering `speed_sel` mid-count fires at the next edge instead of wrapping the full counter.
- `cycle_count` increments by 1 on every edge that registers `cpu_ce`=1. It wraps from 2^CNT_W−1 to 0 and is cleared only by `reset`.
- `running` and `halted` are registered decodes of the state.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Step: `step_req` sampled high in IDLE at edge k → `cpu_ce`=1 for the cycle after edge k only. `cycle_count` updates at edge k. Minimum step-to-step spacing is 2 clocks.
- Run entry at edge k with s constant: pulses fire at edges k+2^s, k+2·2^s, …. For s=0, `cpu_ce` stays high every cycle from edge k+1.
- `run_en` deasserted at edge j → `cpu_ce`=0 from edge j onward, even if j coincides with a terminal count.
- `cpu_halt` high at edge j in RUN → `cpu_ce`=0 from edge j, and `halted`=1 after edge j.
- Leaving HALTED requires `run_en` low for at least one edge. Re-running then requires `run_en` high again with `cpu_halt` low.

## Test plan
- Reset then idle: `reset` high for 2 clocks with all inputs 0 → all outputs 0 and `cpu_ce` never asserts over 50 clocks.
- Single step: a 1-clock `step_req` in IDLE, repeated 3 times with 5-clock gaps → exactly 3 one-cycle `cpu_ce` pulses, each 1 clock after its request, and `cycle_count`=3.
- Run speed 3: `speed_sel`=3, `run_en`=1 for 80 clocks → `cpu_ce` every 8 clocks with the first pulse 8 clocks after entry; `cycle_count`=10; `step_req` pulses during the run have no effect.
- Speed change mid-count: `speed_sel`=4 with `div_cnt` reaching 10, then switch to `speed_sel`=2 → pulse at the next edge, then every 4 clocks.
- Halt: run at s=0, raise `cpu_halt` after 20 pulses → no further `cpu_ce` and `halted`=1. `run_en` 1→0 → IDLE with `halted`=0. With `cpu_halt` still 1, `run_en`=1 → state stays IDLE.
- Reset mid-run and wrap: assert `reset` during RUN at s=0 → `cpu_ce` and `cycle_count` are 0 the next cycle. With `CNT_W`=4, 17 pulses → `cycle_count`=1.
